// File: rtl/gate_mac_seq_if.sv
// Operand/result handshake bundle for gate_mac_seq: input set, result and status.
interface gate_mac_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] x_vec;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] w_vec;
  logic [DATA_WIDTH-1:0]            b;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            out;
  logic                             busy;

  modport master (
    output in_valid, x_vec, w_vec, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, x_vec, w_vec, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/gate_mac_seq.sv
// Sequential signed fixed-point dot product (sum W[i]*X[i] + b), one product per cycle.
// Optional output clamping via GATE_MAC_SAT_EN; default build wraps to DATA_WIDTH bits.
module gate_mac_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int NUM_INPUTS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  gate_mac_seq_if.slave bus
);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(NUM_INPUTS+1);
  localparam int IDX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS-1);
`ifdef GATE_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2} state_t;

  state_t                        state_r, state_next_s;
  logic [IDX_WIDTH-1:0]          idx_r, idx_next_s;
  logic signed [ACC_WIDTH-1:0]   acc_r, acc_next_s, acc_sum_s, bias_s;
  logic [DATA_WIDTH-1:0]         out_r, out_next_s;
  logic                          out_valid_r, out_valid_next_s;
  logic                          load_s;
  logic signed [DATA_WIDTH-1:0]  x_r [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  w_r [NUM_INPUTS];
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic                          in_ready_s;

  function automatic logic signed [2*DATA_WIDTH-1:0] sext2(input logic [DATA_WIDTH-1:0] v);
    sext2 = {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  // Floor-shift back to the I/O Q format, then clamp or wrap to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] fmt(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = a >>> FRACT_WIDTH;
`ifdef GATE_MAC_SAT_EN
    if (sh > SAT_MAX) begin
      fmt = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sh < SAT_MIN) begin
      fmt = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      fmt = sh[DATA_WIDTH-1:0];
    end
`else
    fmt = sh[DATA_WIDTH-1:0];
`endif
  endfunction

  assign in_ready_s    = (state_r == IDLE) | ((state_r == OUT) & bus.out_ready);
  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = (state_r != IDLE);
  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

  assign prod_s    = sext2(x_r[idx_r]) * sext2(w_r[idx_r]);
  assign acc_sum_s = acc_r + {{(ACC_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
  assign bias_s    = $signed({{(ACC_WIDTH-DATA_WIDTH){bus.b[DATA_WIDTH-1]}}, bus.b}) <<< FRACT_WIDTH;

  // Next-state and datapath update; a new set can be taken in OUT without a bubble.
  always_comb begin
    state_next_s     = state_r;
    idx_next_s       = idx_r;
    acc_next_s       = acc_r;
    out_next_s       = out_r;
    out_valid_next_s = out_valid_r;
    load_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ACCUM: begin
        acc_next_s = acc_sum_s;
        idx_next_s = idx_r + IDX_WIDTH'(1);
        if (idx_r == LAST_IDX) begin
          state_next_s     = OUT;
          out_next_s       = fmt(acc_sum_s);
          out_valid_next_s = 1'b1;
        end else begin
          state_next_s     = ACCUM;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_next_s = 1'b0;
          if (bus.in_valid) begin
            load_s = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          out_valid_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s     = IDLE;
        out_valid_next_s = 1'b0;
      end
    endcase
    if (load_s) begin
      acc_next_s   = bias_s;
      idx_next_s   = '0;
      state_next_s = ACCUM;
    end else begin
      load_s = 1'b0;
    end
  end

  // State, accumulator, result and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      acc_r       <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        x_r[i] <= '0;
        w_r[i] <= '0;
      end
    end else begin
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      acc_r       <= acc_next_s;
      out_r       <= out_next_s;
      out_valid_r <= out_valid_next_s;
      if (load_s) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          x_r[i] <= bus.x_vec[i*DATA_WIDTH +: DATA_WIDTH];
          w_r[i] <= bus.w_vec[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_mac_seq.sv
// Directed-vector bench for gate_mac_seq (DW=16, FW=8, NUM_INPUTS=4); honours GATE_MAC_SAT_EN.
module tb_gate_mac_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  gate_mac_seq_if #(.DATA_WIDTH(16), .NUM_INPUTS(4)) bus ();

  gate_mac_seq #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .NUM_INPUTS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] x;
    logic [63:0] w;
    logic [15:0] b;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [15:0] exp_of(input vec_t v);
`ifdef GATE_MAC_SAT_EN
    exp_of = v.exp_sat;
`else
    exp_of = v.exp_wrap;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // One transaction from IDLE: accept, latency, result, optional hold with out_ready low.
  task automatic do_txn(input vec_t v, input int hold, input string name);
    int cyc;
    bus.x_vec    = v.x;
    bus.w_vec    = v.w;
    bus.b        = v.b;
    bus.in_valid = 1'b1;
    check({name, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.x_vec    = {$urandom, $urandom};
    bus.w_vec    = {$urandom, $urandom};
    bus.b        = 16'($urandom);
    check({name, " busy"}, 32'(bus.busy), 32'd1);
    wait_out(cyc);
    check({name, " latency"}, 32'(cyc), 32'd4);
    check({name, " out"}, 32'(bus.out), 32'(exp_of(v)));
    check({name, " in_ready in OUT"}, 32'(bus.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, " hold out"}, 32'(bus.out), 32'(exp_of(v)));
      check({name, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check({name, " in_ready on out_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    check({name, " out_valid cleared"}, 32'(bus.out_valid), 32'd0);
    check({name, " busy cleared"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   cyc;
    int   seq [3];
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{x: 64'h0100_0100_0100_0100, w: 64'h0080_FF00_0100_0200, b: 16'h0040,
                exp_wrap: 16'h02C0, exp_sat: 16'h02C0};
    vecs[1] = '{x: 64'h0000_0000_0000_0001, w: 64'h0000_0000_0000_FFFF, b: 16'h0000,
                exp_wrap: 16'hFFFF, exp_sat: 16'hFFFF};
    vecs[2] = '{x: 64'h7F00_7F00_7F00_7F00, w: 64'h7F00_7F00_7F00_7F00, b: 16'h0000,
                exp_wrap: 16'h0400, exp_sat: 16'h7FFF};
    vecs[3] = '{x: 64'h0040_0000_FE00_0180, w: 64'hFF00_1234_0080_0100, b: 16'hFF80,
                exp_wrap: 16'hFFC0, exp_sat: 16'hFFC0};
    vecs[4] = '{x: 64'h8000_8000_8000_8000, w: 64'h7FFF_7FFF_7FFF_7FFF, b: 16'h0000,
                exp_wrap: 16'h0200, exp_sat: 16'h8000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_vec     = '0;
    bus.w_vec     = '0;
    bus.b         = '0;
    tick();
    tick();
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out", 32'(bus.out), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_txn(vecs[i], 0, $sformatf("vec%0d", i));
    end

    do_txn(vecs[0], 3, "hold");

    // Reset during the second accumulation cycle discards the partial result.
    v = vecs[2];
    bus.x_vec    = v.x;
    bus.w_vec    = v.w;
    bus.b        = v.b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset out", 32'(bus.out), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    do_txn(vecs[0], 0, "after reset");

    // Back-to-back sets with out_ready and in_valid held high.
    seq[0] = 0;
    seq[1] = 3;
    seq[2] = 1;
    bus.out_ready = 1'b1;
    bus.x_vec     = vecs[seq[0]].x;
    bus.w_vec     = vecs[seq[0]].w;
    bus.b         = vecs[seq[0]].b;
    bus.in_valid  = 1'b1;
    check("b2b first in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        bus.x_vec = vecs[seq[k+1]].x;
        bus.w_vec = vecs[seq[k+1]].w;
        bus.b     = vecs[seq[k+1]].b;
      end else begin
        bus.in_valid = 1'b0;
      end
      check($sformatf("b2b%0d busy", k), 32'(bus.busy), 32'd1);
      wait_out(cyc);
      check($sformatf("b2b%0d latency", k), 32'(cyc), 32'd4);
      check($sformatf("b2b%0d out", k), 32'(bus.out), 32'(exp_of(vecs[seq[k]])));
      check($sformatf("b2b%0d in_ready", k), 32'(bus.in_ready), 32'd1);
      tick();
      check($sformatf("b2b%0d out_valid drop", k), 32'(bus.out_valid), 32'd0);
      check($sformatf("b2b%0d busy after", k), 32'(bus.busy), (k < 2) ? 32'd1 : 32'd0);
    end
    bus.out_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
